mem_lsu: RTL and testbench

//  MEM stage of the RV32I pipeline, directly downstream of ex via the ex_mem register.
//  Non-memory results pass straight through to mem_wb.

---
 rtl/mem_lsu_pkg.sv | 48 ++++
 rtl/mem_lsu_align.sv | 44 ++++
 rtl/mem_lsu.sv | 163 ++++++++++++++++
 tb/tb_mem_lsu.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

    // Major opcodes handled by the LSU; everything else is an ALU result.
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Load func3 encodings.
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // Store func3 encodings (sizes line up with LB/LH/LW).
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Level of rst that clears the block.
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_e;

    // True when func3 names a size this unit can move for the given direction.
    function automatic logic func3_ok(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: ok = 1'b1;
                default:                         ok = 1'b0;
            endcase
        end else begin
            case (f3)
                FUNCT3_LB, FUNCT3_LH, FUNCT3_LW,
                FUNCT3_LBU, FUNCT3_LHU:          ok = 1'b1;
                default:                         ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Load-data extension and access size decode: turns the assembled little-endian byte
// buffer into the architectural load result and reports the byte count for a func3.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [31:0] buf_i,
    output logic [31:0] data_o,
    output logic [2:0]  n_o
);

    // Sign/zero extension and byte count selected by func3.
    always_comb begin
        data_o = 32'd0;
        n_o    = 3'd1;
        case (func3_i)
            FUNCT3_LB: begin
                data_o = {{24{buf_i[7]}}, buf_i[7:0]};
                n_o    = 3'd1;
            end
            FUNCT3_LH: begin
                data_o = {{16{buf_i[15]}}, buf_i[15:0]};
                n_o    = 3'd2;
            end
            FUNCT3_LW: begin
                data_o = buf_i;
                n_o    = 3'd4;
            end
            FUNCT3_LBU: begin
                data_o = {24'd0, buf_i[7:0]};
                n_o    = 3'd1;
            end
            FUNCT3_LHU: begin
                data_o = {16'd0, buf_i[15:0]};
                n_o    = 3'd2;
            end
            default: begin
                data_o = 32'd0;
                n_o    = 3'd1;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage of the RV32I pipeline. ALU results pass through with zero latency; loads and
// stores are sequenced one byte at a time over an 8-bit req/ack RAM port, little-endian,
// while stallreq_o holds the upstream pipeline.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        func3_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       sdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BYTE_W-1:0] mem_wdata_o,
    input  logic [BYTE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq_o
);

    lsu_state_e        state_q;
    logic [1:0]        cnt_q;
    logic [31:0]       buf_q;
    logic              is_store_q;
    logic [2:0]        func3_q;
    logic [4:0]        wd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;

    logic              is_mem_s;
    logic              is_store_s;
    logic              start_s;
    logic [31:0]       ext_s;
    logic [2:0]        n_s;
    logic [2:0]        last_s;
    logic              last_hit_s;

    assign is_store_s = (opcode_i == OP_STORE);
    assign is_mem_s   = valid_i && ((opcode_i == OP_LOAD) || is_store_s);
    // An unsupported size is treated as a bubble: no access is started.
    assign start_s    = is_mem_s && func3_ok(is_store_s, func3_i);

    mem_lsu_align u_align (
        .func3_i (func3_q),
        .buf_i   (buf_q),
        .data_o  (ext_s),
        .n_o     (n_s)
    );

    assign last_s     = n_s - 3'd1;
    assign last_hit_s = ({1'b0, cnt_q} == last_s);

    // FSM, byte counter, operand latches and load assembly buffer.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= 2'd0;
            buf_q      <= 32'd0;
            is_store_q <= 1'b0;
            func3_q    <= 3'd0;
            wd_q       <= 5'd0;
            addr_q     <= {ADDR_W{1'b0}};
            sdata_q    <= 32'd0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (start_s) begin
                        is_store_q <= is_store_s;
                        func3_q    <= func3_i;
                        wd_q       <= wd_i;
                        addr_q     <= wdata_i[ADDR_W-1:0];
                        sdata_q    <= sdata_i;
                        buf_q      <= 32'd0;
                        cnt_q      <= 2'd0;
                        state_q    <= LSU_ACCESS;
                    end else begin
                        state_q    <= LSU_IDLE;
                    end
                end
                LSU_ACCESS: begin
                    if (mem_ack_i) begin
                        if (!is_store_q) begin
                            buf_q[{cnt_q, 3'b000} +: BYTE_W] <= mem_rdata_i;
                        end
                        if (last_hit_s) begin
                            state_q <= LSU_DONE;
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                        end
                    end
                end
                LSU_DONE: begin
                    cnt_q   <= 2'd0;
                    state_q <= LSU_IDLE;
                end
                default: begin
                    cnt_q   <= 2'd0;
                    state_q <= LSU_IDLE;
                end
            endcase
        end
    end

    // Output decode; everything is held at zero while reset is asserted so an
    // interrupted access drops its request immediately.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_wdata_o = {BYTE_W{1'b0}};
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stallreq_o  = 1'b0;
        if (rst == RST_ENABLE) begin
            stallreq_o = 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (!valid_i) begin
                        stallreq_o = 1'b0;
                    end else if (is_mem_s) begin
                        stallreq_o = start_s;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                LSU_ACCESS: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = is_store_q;
                    mem_addr_o  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                    mem_wdata_o = sdata_q[{cnt_q, 3'b000} +: BYTE_W];
                    stallreq_o  = 1'b1;
                end
                LSU_DONE: begin
                    if (!is_store_q) begin
                        wd_o    = wd_q;
                        wreg_o  = 1'b1;
                        wdata_o = ext_s;
                    end else begin
                        wreg_o  = 1'b0;
                    end
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a small RAM responder with programmable ack latency and
// an access log, plus a linear sequence of load/store/ALU/reset scenarios.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  func3_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] sdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    int tests = 0;
    int fails = 0;

    // Responder configuration (written by the stimulus) and log (written by the responder).
    int          ack_delay = 0;
    int          rd_base   = 0;
    logic [7:0]  rd_bytes [0:3];
    int          wait_cnt  = 0;
    int          log_n     = 0;
    logic [31:0] log_addr  [0:63];
    logic [7:0]  log_data  [0:63];
    logic        log_we    [0:63];

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .opcode_i    (opcode_i),
        .func3_i     (func3_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .sdata_i     (sdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o)
    );

    // RAM responder: acks a pending request after ack_delay waiting cycles and logs it.
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (mem_req_o === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd_bytes[(log_n - rd_base) & 3];
                log_addr[log_n & 63] = mem_addr_o;
                log_data[log_n & 63] = mem_wdata_o;
                log_we[log_n & 63]   = mem_we_o;
                log_n    = log_n + 1;
                wait_cnt = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one load/store and follow it to its DONE cycle, reporting what was seen there.
    task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] wd,
                          input logic [31:0] addr, input logic [31:0] sd,
                          output int stalls, output logic [31:0] d_wdata, output logic d_wreg,
                          output logic [4:0] d_wd, output logic d_req, output int base);
        bit done;
        bit wreg_in_stall;
        @(posedge clk);
        #1;
        base     = log_n;
        rd_base  = log_n;
        valid_i  = 1'b1;
        opcode_i = op;
        func3_i  = f3;
        wd_i     = wd;
        wreg_i   = 1'b1;
        wdata_i  = addr;
        sdata_i  = sd;
        stalls   = 0;
        done     = 1'b0;
        wreg_in_stall = 1'b0;
        d_wdata  = 32'hxxxxxxxx;
        d_wreg   = 1'bx;
        d_wd     = 5'bxxxxx;
        d_req    = 1'bx;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (stallreq_o === 1'b1) begin
                stalls = stalls + 1;
                if (wreg_o !== 1'b0) wreg_in_stall = 1'b1;
            end else begin
                d_wdata = wdata_o;
                d_wreg  = wreg_o;
                d_wd    = wd_o;
                d_req   = mem_req_o;
                done    = 1'b1;
            end
        end
        chk("access_completes", {31'd0, done}, 32'd1);
        chk("wreg_low_while_stalled", {31'd0, wreg_in_stall}, 32'd0);
    endtask

    // Drop valid for a cycle and confirm no writeback lingers.
    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk(tag, {31'd0, wreg_o}, 32'd0);
    endtask

    int          stalls;
    int          base;
    logic [31:0] d_wdata;
    logic        d_wreg;
    logic [4:0]  d_wd;
    logic        d_req;
    logic [7:0]  sw_bytes [0:3];
    logic [31:0] lw_addrs [0:3];

    initial begin
        rst      = 1'b0;
        valid_i  = 1'b1;
        opcode_i = 7'b0110011;
        func3_i  = 3'b000;
        wd_i     = 5'd9;
        wreg_i   = 1'b1;
        wdata_i  = 32'h0000_1234;
        sdata_i  = 32'd0;
        for (int i = 0; i < 4; i++) rd_bytes[i] = 8'h00;

        // Reset: all outputs forced low even with a valid ALU op presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wreg",   {31'd0, wreg_o}, 32'd0);
        chk("rst_wd",     {27'd0, wd_o}, 32'd0);
        chk("rst_wdata",  wdata_o, 32'd0);
        chk("rst_stall",  {31'd0, stallreq_o}, 32'd0);
        chk("rst_req",    {31'd0, mem_req_o}, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("idle_novalid_wreg",  {31'd0, wreg_o}, 32'd0);
        chk("idle_novalid_wdata", wdata_o, 32'd0);

        // SW 0xDEADBEEF @0x100, ack every cycle.
        sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
        ack_delay = 0;
        mem_op(7'b0100011, 3'b010, 5'd3, 32'h0000_0100, 32'hDEAD_BEEF,
               stalls, d_wdata, d_wreg, d_wd, d_req, base);
        chk("sw_stall_cycles", stalls, 32'd5);
        chk("sw_done_wreg",    {31'd0, d_wreg}, 32'd0);
        chk("sw_done_wdata",   d_wdata, 32'd0);
        chk("sw_done_req",     {31'd0, d_req}, 32'd0);
        chk("sw_byte_count",   log_n - base, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("sw_addr", log_addr[(base + k) & 63], 32'h0000_0100 + k);
            chk("sw_data", {24'd0, log_data[(base + k) & 63]}, {24'd0, sw_bytes[k]});
            chk("sw_we",   {31'd0, log_we[(base + k) & 63]}, 32'd1);
        end
        idle_cycle("sw_after_wreg");

        // LB @0x101 returning 0x80: sign-extended, writeback for exactly one cycle.
        rd_bytes[0] = 8'h80;
        mem_op(7'b0000011, 3'b000, 5'd5, 32'h0000_0101, 32'd0,
               stalls, d_wdata, d_wreg, d_wd, d_req, base);
        chk("lb_stall_cycles", stalls, 32'd2);
        chk("lb_wdata",        d_wdata, 32'hFFFF_FF80);
        chk("lb_wreg",         {31'd0, d_wreg}, 32'd1);
        chk("lb_wd",           {27'd0, d_wd}, 32'd5);
        chk("lb_addr",         log_addr[base & 63], 32'h0000_0101);
        chk("lb_we",           {31'd0, log_we[base & 63]}, 32'd0);
        idle_cycle("lb_wreg_one_cycle");

        // LBU @0x101 returning 0x80: zero-extended.
        mem_op(7'b0000011, 3'b100, 5'd6, 32'h0000_0101, 32'd0,
               stalls, d_wdata, d_wreg, d_wd, d_req, base);
        chk("lbu_wdata", d_wdata, 32'h0000_0080);
        chk("lbu_wreg",  {31'd0, d_wreg}, 32'd1);
        idle_cycle("lbu_after_wreg");

        // LH @0x103 misaligned, ack 3 cycles late per byte.
        rd_bytes[0] = 8'h34; rd_bytes[1] = 8'h92;
        ack_delay = 3;
        mem_op(7'b0000011, 3'b001, 5'd8, 32'h0000_0103, 32'd0,
               stalls, d_wdata, d_wreg, d_wd, d_req, base);
        chk("lh_stall_cycles", stalls, 32'd9);
        chk("lh_wdata",        d_wdata, 32'hFFFF_9234);
        chk("lh_byte_count",   log_n - base, 32'd2);
        chk("lh_addr0",        log_addr[base & 63], 32'h0000_0103);
        chk("lh_addr1",        log_addr[(base + 1) & 63], 32'h0000_0104);
        ack_delay = 0;

        // ADD passes through with no stall, immediately followed by a wrapping LW.
        @(posedge clk);
        #1;
        valid_i  = 1'b1;
        opcode_i = 7'b0110011;
        func3_i  = 3'b000;
        wd_i     = 5'd7;
        wreg_i   = 1'b1;
        wdata_i  = 32'h0000_0055;
        @(negedge clk);
        chk("add_wd",    {27'd0, wd_o}, 32'd7);
        chk("add_wreg",  {31'd0, wreg_o}, 32'd1);
        chk("add_wdata", wdata_o, 32'h0000_0055);
        chk("add_stall", {31'd0, stallreq_o}, 32'd0);
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
        lw_addrs[0] = 32'hFFFF_FFFE; lw_addrs[1] = 32'hFFFF_FFFF;
        lw_addrs[2] = 32'h0000_0000; lw_addrs[3] = 32'h0000_0001;
        mem_op(7'b0000011, 3'b010, 5'd12, 32'hFFFF_FFFE, 32'd0,
               stalls, d_wdata, d_wreg, d_wd, d_req, base);
        chk("lw_stall_cycles", stalls, 32'd5);
        chk("lw_wdata",        d_wdata, 32'h4433_2211);
        chk("lw_wd",           {27'd0, d_wd}, 32'd12);
        for (int k = 0; k < 4; k++) begin
            chk("lw_addr_wrap", log_addr[(base + k) & 63], lw_addrs[k]);
        end

        // Unsupported load size: no access, no stall, no writeback.
        @(posedge clk);
        #1;
        base     = log_n;
        valid_i  = 1'b1;
        opcode_i = 7'b0000011;
        func3_i  = 3'b011;
        wdata_i  = 32'h0000_0040;
        @(negedge clk);
        chk("bad_f3_stall", {31'd0, stallreq_o}, 32'd0);
        chk("bad_f3_wreg",  {31'd0, wreg_o}, 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("bad_f3_no_req",   {31'd0, mem_req_o}, 32'd0);
        chk("bad_f3_no_bytes", log_n - base, 32'd0);

        // Reset asserted while byte 2 of a SW is being requested.
        @(posedge clk);
        #1;
        base     = log_n;
        valid_i  = 1'b1;
        opcode_i = 7'b0100011;
        func3_i  = 3'b010;
        wdata_i  = 32'h0000_0200;
        sdata_i  = 32'h1122_3344;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("abort_req",   {31'd0, mem_req_o}, 32'd0);
        chk("abort_stall", {31'd0, stallreq_o}, 32'd0);
        chk("abort_addr",  mem_addr_o, 32'd0);
        chk("abort_bytes", log_n - base, 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_stall", {31'd0, stallreq_o}, 32'd0);
        chk("post_abort_req",   {31'd0, mem_req_o}, 32'd0);

        // A fresh LB after the abort starts from byte 0 at its own address.
        rd_bytes[0] = 8'h7F;
        mem_op(7'b0000011, 3'b000, 5'd4, 32'h0000_0300, 32'd0,
               stalls, d_wdata, d_wreg, d_wd, d_req, base);
        chk("post_abort_lb_stall", stalls, 32'd2);
        chk("post_abort_lb_addr",  log_addr[base & 63], 32'h0000_0300);
        chk("post_abort_lb_wdata", d_wdata, 32'h0000_007F);
        idle_cycle("post_abort_after_wreg");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
